div8x8: RTL and testbench



---
 rtl/div8x8_pkg.sv | 20 ++
 rtl/div8x8_sub9.sv | 19 +
 rtl/div8x8.sv | 139 +++++++++++++
 tb/tb_div8x8.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div8x8_pkg.sv
// Shared constants and types for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default operand width, iteration-counter width.
package div8x8_pkg;

  // Default operand/quotient/remainder width; also the number of iterations.
  localparam int DEF_WIDTH = 8;

  // Width of the iteration counter for the default width.
  localparam int CNT_W = $clog2(DEF_WIDTH);

  // Divider control states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div8x8_sub9.sv
// Combinational W-bit subtractor used for the divider's trial subtract.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (W-bit minuend/subtrahend) -> diff = a - b (W bits), borrow = (a < b).
module sub9 #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // One extra bit on each side so the carry-out of the subtract is the borrow.
  always_comb begin
    {borrow, diff} = {1'b0, a} - {1'b0, b};
  end

endmodule

// File: rtl/div8x8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: WIDTH+1 cycles start-to-done_flag; 1 cycle for a zero divisor.
// Backpressure: none; start is only sampled in IDLE, ignored otherwise (no queue).
// Ports: clk, reset (sync, active-high), start, dataa (dividend), datab (divisor)
//        -> quotient, remainder (registered), busy, done_flag (1-cycle), div_by_zero.
module div8x8
  import div8x8_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done_flag,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] dvd;        // dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs;        // divisor, held for the whole operation
  logic [WIDTH-1:0] rem_r;      // partial remainder, always < divisor between steps
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   t_diff;
  logic             t_borrow;
  logic             trial_neg;
  logic [WIDTH-1:0] rem_nxt;
  logic             last_iter;
  logic             accept;

  // Shift step: bring the next dividend bit into the (WIDTH+1)-bit remainder.
  assign r_shift = {rem_r, dvd[WIDTH-1]};

  sub9 #(
    .W(WIDTH + 1)
  ) u_sub (
    .a      (r_shift),
    .b      ({1'b0, dvs}),
    .diff   (t_diff),
    .borrow (t_borrow)
  );

  // Because the stored remainder is below the divisor, the shifted value is below
  // twice the divisor, so the trial MSB and the subtractor borrow always agree;
  // either one marks a failed trial.
  assign trial_neg = t_diff[WIDTH] | t_borrow;

  // A successful trial leaves a difference below the divisor, so WIDTH bits suffice.
  // A failed trial keeps r_shift, which is then also below the divisor.
  assign rem_nxt   = trial_neg ? r_shift[WIDTH-1:0] : t_diff[WIDTH-1:0];

  assign last_iter = (count == CW'(WIDTH - 1));
  assign accept    = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done_flag = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (datab == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_flag = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. Results and div_by_zero only change on an accepted
  // start or while iterating, so they hold through DONE and the following IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      dvd         <= '0;
      dvs         <= '0;
      rem_r       <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        if (datab != '0) begin
          dvd         <= dataa;
          dvs         <= datab;
          rem_r       <= '0;
          count       <= '0;
          quotient    <= '0;
          remainder   <= '0;
          div_by_zero <= 1'b0;
        end else begin
          // Zero divisor: report without iterating.
          quotient    <= '1;
          remainder   <= dataa;
          div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        dvd       <= dvd << 1;
        rem_r     <= rem_nxt;
        remainder <= rem_nxt;
        // Quotient bits enter at the LSB; after WIDTH steps the first lands at the MSB.
        quotient  <= {quotient[WIDTH-2:0], ~trial_neg};
        count     <= count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_div8x8.sv
// Self-checking bench for div8x8: scoreboard of expected results, compared on done_flag.
// Latency: checks done_flag cycle and busy cycle count for every operation.
// Backpressure: exercises start held during RUN/DONE and start asserted with reset.
module tb_div8x8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dataa;
  logic [7:0] datab;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done_flag;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         busy;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  div8x8 dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done_flag   (done_flag),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Build the expected result for an operation whose start is sampled at the next edge.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int k);
    exp_t e;
    if (b == 8'd0) begin
      e.q = 8'hFF;  e.r = a;  e.dbz = 1'b1;  e.busy = 0;  e.done_cyc = k;
    end else begin
      e.q = a / b;  e.r = a % b;  e.dbz = 1'b0;  e.busy = 8;  e.done_cyc = k + 8;
    end
    return e;
  endfunction

  // Output monitor: pops and compares on every done_flag.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done_flag) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient",    quotient,    e.q);
        check("remainder",   remainder,   e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        check("busy_cycles", busy_cnt,    e.busy);
        check("done_cycle",  cyc,         e.done_cyc);
      end
      busy_cnt = 0;
    end
  end

  // Issue one operation from IDLE and wait until its DONE cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    bit seen = 1'b0;
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_flag) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_quotient"},  quotient,    32'd0);
    check({tag, "_remainder"}, remainder,   32'd0);
    check({tag, "_busy"},      busy,        32'd0);
    check({tag, "_done"},      done_flag,   32'd0);
    check({tag, "_dbz"},       div_by_zero, 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    bit seen;

    // Reset with start asserted: reset wins, start is dropped.
    reset = 1'b1;
    start = 1'b1;
    dataa = 8'd20;
    datab = 8'd4;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", busy, 32'd0);
    check("idle_after_reset_done", done_flag, 32'd0);

    // Directed cases.
    do_op(8'd100, 8'd7);
    do_op(8'd255, 8'd1);
    do_op(8'd5,   8'd9);
    do_op(8'd200, 8'd200);
    do_op(8'd77,  8'd0);
    do_op(8'd10,  8'd3);

    // Results hold in IDLE after completion.
    @(negedge clk);
    check("hold_quotient",  quotient,  32'd3);
    check("hold_remainder", remainder, 32'd1);

    // start held through RUN and DONE: one result, then the held request runs.
    @(negedge clk);
    dataa = 8'd100;
    datab = 8'd7;
    start = 1'b1;
    k = cyc + 1;
    sb.push_back(model(8'd100, 8'd7, k));
    sb.push_back(model(8'd50, 8'd5, k + 10));
    @(negedge clk);
    dataa = 8'd50;
    datab = 8'd5;
    dones = 0;
    for (int i = 0; i < 40 && dones < 2; i++) begin
      @(negedge clk);
      if (done_flag) dones++;
    end
    start = 1'b0;
    if (dones < 2) check("held_start_timeout", dones, 32'd2);

    // Reset during cycle 4 of an operation aborts it without done_flag.
    @(negedge clk);
    @(negedge clk);
    dataa = 8'd100;
    datab = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    busy_cnt = 0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    do_op(8'd9, 8'd2);

    // Randomized sweep with non-zero divisors.
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
